// File: rtl/decade_tally.sv
// -----------------------------------------------------------------------------
// decade_tally
//   Consumer of a 10-line one-hot decade counter. The one-hot lines are
//   registered once (stage 1) and then decoded (stage 2) into a BCD units
//   digit. Every legal 9->0 step increments a cascaded BCD tally of
//   UPPER_DIGITS digits. Malformed codes, illegal steps and tally overflow
//   raise sticky diagnostic flags.
//
// Parameters
//   UPPER_DIGITS  number of cascaded upper BCD digits (1..4)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   onehot      in   [9:0] decade counter lines, bit k high = count k
//   err_clr     in   synchronous clear of code_err / step_err / overflow
//   units_bcd   out  [3:0] BCD units digit of the last legal sample
//   upper_bcd   out  [4*UPPER_DIGITS-1:0] wrap tally, LS digit in [3:0]
//   wrap_pulse  out  one-cycle pulse per detected 9->0 wrap
//   valid       out  last decoded sample was a legal one-hot code
//   code_err    out  sticky: a sample was zero or had more than one bit set
//   step_err    out  sticky: legal sample was not prev, prev+1 or 9->0
//   overflow    out  sticky: tally wrapped from all 9s to all 0s
// -----------------------------------------------------------------------------
module decade_tally #(
  parameter int UPPER_DIGITS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [9:0]                  onehot,
  input  logic                        err_clr,
  output logic [3:0]                  units_bcd,
  output logic [4*UPPER_DIGITS-1:0]   upper_bcd,
  output logic                        wrap_pulse,
  output logic                        valid,
  output logic                        code_err,
  output logic                        step_err,
  output logic                        overflow
);

  // Stage 1 sample. s1_vld marks that s1 holds a real sample rather than the
  // reset value, so the cleared register is not mistaken for a zero code.
  logic [9:0] s1;
  logic       s1_vld;

  // Step tracking
  logic [3:0] prev_idx;
  logic       prev_ok;

  // Decode of s1
  logic [3:0] ones;
  logic [3:0] idx;
  logic       legal;

  // Step classification
  logic       check_en;
  logic       step_same;
  logic       step_adv;
  logic       step_wrap;
  logic       do_wrap;
  logic       do_bad_step;
  logic       code_set;

  // Tally increment
  logic [4*UPPER_DIGITS-1:0] upper_inc;
  logic                      tally_full;

  // ---------------------------------------------------------------------------
  // Stage 1: unconditional capture of the one-hot lines
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1     <= onehot;
      s1_vld <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 decode: count set bits and remember the position of the set bit.
  // idx is only meaningful when exactly one bit is set.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int k = 0; k < 10; k++) begin
      if (s1[k]) begin
        ones = ones + 4'd1;
        idx  = 4'(k);
      end
    end
    legal = (ones == 4'd1);
  end

  // Step classification against the previous legal index. The first legal
  // sample after reset or after an illegal sample is never step-checked.
  assign check_en    = s1_vld && legal && prev_ok;
  assign step_same   = (idx == prev_idx);
  assign step_adv    = (prev_idx < 4'd9) && (idx == prev_idx + 4'd1);
  assign step_wrap   = (prev_idx == 4'd9) && (idx == 4'd0);
  assign do_wrap     = check_en && step_wrap;
  assign do_bad_step = check_en && !(step_same || step_adv || step_wrap);
  assign code_set    = s1_vld && !legal;

  // ---------------------------------------------------------------------------
  // BCD ripple increment of the tally. The carry out of the top digit means
  // every digit was 9, i.e. the tally is about to roll over to all zeros.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic carry;
    carry     = 1'b1;
    upper_inc = upper_bcd;
    for (int i = 0; i < UPPER_DIGITS; i++) begin
      if (carry) begin
        if (upper_bcd[4*i +: 4] == 4'd9) begin
          upper_inc[4*i +: 4] = 4'd0;
        end else begin
          upper_inc[4*i +: 4] = upper_bcd[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    tally_full = carry;
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers: digit, tally, pulse and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      units_bcd  <= '0;
      upper_bcd  <= '0;
      wrap_pulse <= 1'b0;
      valid      <= 1'b0;
      code_err   <= 1'b0;
      step_err   <= 1'b0;
      overflow   <= 1'b0;
      prev_idx   <= '0;
      prev_ok    <= 1'b0;
    end else begin
      wrap_pulse <= do_wrap;

      if (do_wrap) begin
        upper_bcd <= upper_inc;
      end

      // A new error in the same cycle as err_clr takes priority over the clear.
      code_err <= code_set                   || (code_err && !err_clr);
      step_err <= do_bad_step                || (step_err && !err_clr);
      overflow <= (do_wrap && tally_full)    || (overflow && !err_clr);

      if (s1_vld) begin
        if (legal) begin
          units_bcd <= idx;
          valid     <= 1'b1;
          prev_idx  <= idx;
          prev_ok   <= 1'b1;
        end else begin
          valid     <= 1'b0;
          prev_ok   <= 1'b0;
        end
      end
    end
  end

endmodule
